// File: rtl/cpc_ram_bank_ctrl.sv
// ---------------------------------------------------------------------------
// cpc_ram_bank_ctrl
//
// RAM expansion bank controller for a Z80 (Amstrad CPC style) bus. An OUT to
// the gate-array port (A15=0, D[7:6]=11) selects a RAM configuration (D[2:0])
// and a 64KB expansion bank (D[5:3], optionally extended with inverted
// A[13:11]). The configuration decides which 16KB CPU block is redirected to
// the expansion SRAM and which page of the selected bank it maps to.
//
// A port write must be seen on two consecutive rising clock edges before it
// is committed. This rejects single-cycle glitches on the IO strobes. Exactly
// one commit happens per IO cycle.
//
// Ports
//   CLK        in   Z80 bus clock, the only clock
//   RESET      in   asynchronous active-high reset
//   A          in   address bus A[15:8]
//   D          in   data bus
//   IOREQ_B    in   IO request, active low
//   WR_B       in   write strobe, active low
//   M1_B       in   M1 cycle, active low (IOREQ_B=0 with M1_B=0 is INTA)
//   MREQ_B     in   memory request, active low
//   RFSH_B     in   refresh cycle, active low
//   RAMDIS     out  high = internal RAM disabled for the current block
//   RAMCS_B    out  expansion SRAM chip select, active low
//   RAMADR_HI  out  SRAM address bits [NBANKBITS+15:14] = {bank, page}
//   CFG_Q      out  committed RAM configuration (debug view)
// ---------------------------------------------------------------------------
module cpc_ram_bank_ctrl #(
    parameter int NBANKBITS   = 3,
    parameter int NBANKS      = 2 ** NBANKBITS,
    parameter bit EXT_PORT_EN = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [7:0]             A,
    input  logic [7:0]             D,
    input  logic                   IOREQ_B,
    input  logic                   WR_B,
    input  logic                   M1_B,
    input  logic                   MREQ_B,
    input  logic                   RFSH_B,
    output logic                   RAMDIS,
    output logic                   RAMCS_B,
    output logic [NBANKBITS+1:0]   RAMADR_HI,
    output logic [2:0]             CFG_Q
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   pw_s;
    logic                   capture_s;
    logic                   commit_s;
    logic                   discard_s;

    logic [2:0]             pend_cfg_r;
    logic [2:0]             pend_bsel_r;
    logic [2:0]             pend_ext_r;

    logic [2:0]             cfg_r;
    logic [NBANKBITS-1:0]   bank_r;
    logic [5:0]             bank_src_s;
    logic [NBANKBITS-1:0]   bank_nxt_s;

    logic [1:0]             blk_s;
    logic                   sel_raw_s;
    logic [1:0]             page_s;
    logic                   bank_pop_s;
    logic                   sel_s;

    // A[10:8] play no part in the decode.
    logic                   unused_a_s;
    assign unused_a_s = ^A[2:0];

    // Port write match. M1_B=1 is required so an interrupt acknowledge
    // (IOREQ_B and M1_B both low) can never look like a port write.
    assign pw_s = ~IOREQ_B & ~WR_B & M1_B & ~A[7] & D[7] & D[6];

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        commit_s    = 1'b0;
        discard_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pw_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (pw_s) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    // Strobe vanished after one edge: treat as a glitch.
                    discard_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Wait for the IO cycle to end so a long write commits once.
                if (IOREQ_B || WR_B) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pending write registers, loaded on the first matching edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_cfg_r  <= 3'b000;
            pend_bsel_r <= 3'b000;
            pend_ext_r  <= 3'b000;
        end else if (capture_s) begin
            pend_cfg_r  <= D[2:0];
            pend_bsel_r <= D[5:3];
            pend_ext_r  <= A[5:3];
        end else if (discard_s) begin
            pend_cfg_r  <= 3'b000;
            pend_bsel_r <= 3'b000;
            pend_ext_r  <= 3'b000;
        end else begin
            pend_cfg_r  <= pend_cfg_r;
            pend_bsel_r <= pend_bsel_r;
            pend_ext_r  <= pend_ext_r;
        end
    end

    // Bank number from the pending write. The extended port form puts the
    // inverted A[13:11] above D[5:3]; only the low NBANKBITS are kept.
    always_comb begin
        bank_src_s = 6'b000000;
        if (EXT_PORT_EN) begin
            bank_src_s = {~pend_ext_r, pend_bsel_r};
        end else begin
            bank_src_s = {3'b000, pend_bsel_r};
        end
        bank_nxt_s = NBANKBITS'(bank_src_s);
    end

    // Committed configuration and bank; they only ever move on a clock edge,
    // so the decode below cannot glitch on a configuration change.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cfg_r  <= 3'b000;
            bank_r <= {NBANKBITS{1'b0}};
        end else if (commit_s) begin
            cfg_r  <= pend_cfg_r;
            bank_r <= bank_nxt_s;
        end else begin
            cfg_r  <= cfg_r;
            bank_r <= bank_r;
        end
    end

    assign blk_s = A[7:6];

    // Block-to-page decode for the committed configuration.
    always_comb begin
        sel_raw_s = 1'b0;
        page_s    = 2'b00;
        case (cfg_r)
            3'd0: begin
                sel_raw_s = 1'b0;
                page_s    = 2'b00;
            end
            3'd1, 3'd3: begin
                if (blk_s == 2'd3) begin
                    sel_raw_s = 1'b1;
                    page_s    = 2'd3;
                end else begin
                    sel_raw_s = 1'b0;
                    page_s    = 2'b00;
                end
            end
            3'd2: begin
                sel_raw_s = 1'b1;
                page_s    = blk_s;
            end
            3'd4, 3'd5, 3'd6, 3'd7: begin
                // Block 1 maps to page cfg-4, i.e. the low two cfg bits.
                if (blk_s == 2'd1) begin
                    sel_raw_s = 1'b1;
                    page_s    = cfg_r[1:0];
                end else begin
                    sel_raw_s = 1'b0;
                    page_s    = 2'b00;
                end
            end
            default: begin
                sel_raw_s = 1'b0;
                page_s    = 2'b00;
            end
        endcase
    end

    // An unpopulated bank falls back to internal RAM.
    assign bank_pop_s = (32'(bank_r) < NBANKS);
    assign sel_s      = sel_raw_s & bank_pop_s;

    // Refresh cycles never reach the expansion SRAM and never hide internal RAM.
    assign RAMDIS    = sel_s & RFSH_B;
    assign RAMCS_B   = ~(sel_s & ~MREQ_B & RFSH_B);
    assign RAMADR_HI = sel_s ? {bank_r, page_s} : {(NBANKBITS + 2){1'b0}};
    assign CFG_Q     = cfg_r;

endmodule
